// File: rtl/acce_stream_ctrl_pkg.sv
// acce_stream_ctrl_pkg: shared state encoding, address width and weight-word default
package acce_stream_ctrl_pkg;
  localparam int AW = 16;
  localparam int WT_WORDS_DEF = 25;
  typedef enum logic [2:0] {IDLE, WEIGHT, WT_WAIT, PIXEL, DRAIN, FIN} state_t;
endpackage

// File: rtl/acce_stream_ctrl_result_writer.sv
// acce_result_writer: result capture, destination addressing, drop flag and drain timeout
module acce_result_writer
  import acce_stream_ctrl_pkg::*;
#(
  parameter int TO_CYC = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic          drain,
  input  logic          fin,
  input  logic [AW-1:0] dst_base,
  input  logic          acc_rvalid,
  input  logic [31:0]   acc_rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [31:0]   mem_wr_data,
  output logic          dropped,
  output logic          timeout
);
  localparam int TW = $clog2(TO_CYC + 1);
  logic [AW-1:0] res_cnt;
  logic [TW-1:0] to_cnt;
  assign mem_wr_en   = acc_rvalid && active;
  assign mem_wr_addr = mem_wr_en ? dst_base + res_cnt : '0;
  assign mem_wr_data = mem_wr_en ? acc_rdata : '0;
  // to_cnt holds cycles since the last capture, so FIN lands when it would reach TO_CYC
  assign timeout = drain && !mem_wr_en && to_cnt == TW'(TO_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_cnt <= '0;
      to_cnt  <= '0;
      dropped <= 1'b0;
    end else begin
      res_cnt <= !active ? '0 : res_cnt + AW'(mem_wr_en);
      to_cnt  <= mem_wr_en ? TW'(1) : drain ? to_cnt + 1'b1 : '0;
      dropped <= fin ? 1'b0 : dropped | (acc_rvalid && !active);
    end
endmodule

// File: rtl/acce_stream_ctrl.sv
// acce_stream_ctrl: streams weights and pixels from memory to the accelerator and writes results back
module acce_stream_ctrl
  import acce_stream_ctrl_pkg::*;
#(
  parameter int WT_WORDS = WT_WORDS_DEF,
  parameter int TO_CYC   = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] px_words,
  input  logic [AW-1:0] dst_base,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [31:0]   mem_wr_data,
  output logic [31:0]   acc_data,
  output logic          acc_valid,
  input  logic          acc_weight_ing,
  input  logic [31:0]   acc_rdata,
  input  logic          acc_rvalid,
  input  logic          acc_conv_done,
  output logic          bus_free,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_t state, nxt;
  logic [AW-1:0] src_q, px_q, dst_q, rd_cnt;
  logic cd_lat, to_err, dropped, timeout;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? WEIGHT : IDLE;
      WEIGHT:  nxt = rd_cnt == AW'(WT_WORDS - 1) ? WT_WAIT : WEIGHT;
      WT_WAIT: nxt = !acc_valid && !acc_weight_ing ? PIXEL : WT_WAIT;
      PIXEL:   nxt = rd_cnt == px_q - 1'b1 ? DRAIN : PIXEL;
      DRAIN:   nxt = acc_conv_done || cd_lat || timeout ? FIN : DRAIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign mem_rd_en   = state == WEIGHT || state == PIXEL;
  assign mem_rd_addr = mem_rd_en ? src_q + (state == PIXEL ? AW'(WT_WORDS) : '0) + rd_cnt : '0;
  assign acc_data    = acc_valid ? mem_rdata : '0;
  assign busy        = state != IDLE;
  assign bus_free    = busy;
  assign done        = state == FIN;
  assign err         = done && (to_err || dropped);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= '0;
      px_q      <= '0;
      dst_q     <= '0;
      rd_cnt    <= '0;
      acc_valid <= 1'b0;
      cd_lat    <= 1'b0;
      to_err    <= 1'b0;
    end else begin
      state     <= nxt;
      rd_cnt    <= nxt != state ? '0 : rd_cnt + AW'(mem_rd_en);
      acc_valid <= mem_rd_en;
      // an early layer-complete pulse is held until DRAIN can act on it
      cd_lat    <= state == IDLE || state == FIN ? 1'b0 : cd_lat | acc_conv_done;
      to_err    <= state == IDLE ? 1'b0 : to_err | (state == DRAIN && timeout && !acc_conv_done && !cd_lat);
      if (state == IDLE && start) begin
        src_q <= src_base;
        px_q  <= px_words == '0 ? AW'(1) : px_words;
        dst_q <= dst_base;
      end
    end
  acce_result_writer #(.TO_CYC(TO_CYC)) u_writer (
    .clk(clk),
    .rst_n(rst_n),
    .active(busy),
    .drain(state == DRAIN),
    .fin(done),
    .dst_base(dst_q),
    .acc_rvalid(acc_rvalid),
    .acc_rdata(acc_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .dropped(dropped),
    .timeout(timeout)
  );
endmodule

// File: tb/tb_acce_stream_ctrl.sv
// tb_acce_stream_ctrl: table vectors, corner sequences and randomized layers against a transaction model
module tb_acce_stream_ctrl;
  localparam int WT = 25;
  localparam int TO = 16;
  typedef struct {
    logic [15:0] src, px, dst;
    int nres, hold;
    bit cd, ecd, err;
    logic [15:0] a_px, a_last;
    int n_rd, px_ofs, done_ofs;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] src_base = 0, px_words = 0, dst_base = 0;
  logic mem_rd_en, mem_wr_en, acc_valid, bus_free, busy, done, err;
  logic [15:0] mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rdata = 0, mem_wr_data, acc_data;
  logic acc_weight_ing = 0, acc_rvalid = 0, acc_conv_done = 0;
  logic [31:0] acc_rdata = 0;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int rd_cyc[$], av_cyc[$], done_cyc[$];
  logic [15:0] rd_adr[$], wr_adr[$];
  logic [31:0] av_dat[$], wr_dat[$], exp_dat[$];
  logic done_err[$];
  vec_t tbl[6];
  acce_stream_ctrl #(.WT_WORDS(WT), .TO_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .px_words(px_words),
    .dst_base(dst_base), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .acc_data(acc_data), .acc_valid(acc_valid), .acc_weight_ing(acc_weight_ing),
    .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid), .acc_conv_done(acc_conv_done),
    .bus_free(bus_free), .busy(busy), .done(done), .err(err)
  );
  function automatic logic [31:0] memf(input logic [15:0] a);
    return {a ^ 16'h5A3C, a};
  endfunction
  function automatic logic any_out();
    return |{mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, acc_data, acc_valid,
             bus_free, busy, done, err};
  endfunction
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rdata <= mem_rd_en ? memf(mem_rd_addr) : 32'hDEAD_BEEF;
  always @(negedge clk) begin
    if (mem_rd_en) begin rd_cyc.push_back(cyc); rd_adr.push_back(mem_rd_addr); end
    if (acc_valid) begin av_cyc.push_back(cyc); av_dat.push_back(acc_data); end
    if (mem_wr_en) begin wr_adr.push_back(mem_wr_addr); wr_dat.push_back(mem_wr_data); end
    if (done) begin done_cyc.push_back(cyc); done_err.push_back(err); end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    rd_cyc.delete(); rd_adr.delete(); av_cyc.delete(); av_dat.delete();
    wr_adr.delete(); wr_dat.delete(); done_cyc.delete(); done_err.delete(); exp_dat.delete();
  endtask
  task automatic run_layer(input vec_t v, output int s, output int last_res, output int cd_cyc);
    int pxe, t;
    logic [31:0] d;
    pxe = v.px == 0 ? 1 : int'(v.px);
    clear();
    src_base = v.src; px_words = v.px; dst_base = v.dst;
    start = 1; s = cyc; last_res = -1; cd_cyc = -1;
    step();
    start = 0;
    t = 0;
    while (av_cyc.size() < WT + pxe && t < 400) begin
      acc_weight_ing = cyc >= s + 2 && cyc <= s + 26 + v.hold;
      acc_conv_done = v.ecd && cyc == s + 5;
      step();
      t++;
    end
    acc_weight_ing = 0; acc_conv_done = 0;
    chk("stream_in_budget", 32'(t < 400), 1);
    for (int k = 0; k < v.nres; k++) begin
      repeat ($urandom_range(0, 2)) step();
      d = $urandom;
      acc_rvalid = 1; acc_rdata = d; exp_dat.push_back(d); last_res = cyc;
      step();
      acc_rvalid = 0;
    end
    repeat (2) step();
    if (v.cd) begin
      acc_conv_done = 1; cd_cyc = cyc;
      step();
      acc_conv_done = 0;
    end
    t = 0;
    while (done_cyc.size() == 0 && t < 100) begin step(); t++; end
    chk("done_in_budget", 32'(t < 100), 1);
    repeat (2) step();
  endtask
  // reads are contiguous from src; pixels start the cycle after weight_ing is first seen low
  task automatic check_layer(input vec_t v, input int s, input logic exp_err);
    int pxe, ec;
    logic [15:0] a;
    pxe = v.px == 0 ? 1 : int'(v.px);
    chk("rd_count", rd_adr.size(), WT + pxe);
    chk("av_count", av_dat.size(), WT + pxe);
    for (int i = 0; i < WT + pxe; i++) begin
      a = v.src + 16'(i);
      ec = i < WT ? s + 1 + i : s + 28 + v.hold + i - WT;
      if (i < rd_adr.size()) begin
        chk("rd_addr", 32'(rd_adr[i]), 32'(a));
        chk("rd_cycle", rd_cyc[i], ec);
      end
      if (i < av_dat.size()) begin
        chk("av_data", av_dat[i], memf(a));
        chk("av_cycle", av_cyc[i], ec + 1);
      end
    end
    chk("wr_count", wr_adr.size(), exp_dat.size());
    for (int k = 0; k < wr_adr.size() && k < exp_dat.size(); k++) begin
      chk("wr_addr", 32'(wr_adr[k]), 32'(v.dst + 16'(k)));
      chk("wr_data", wr_dat[k], exp_dat[k]);
    end
    chk("done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("done_err", 32'(done_err[0]), 32'(exp_err));
  endtask
  initial begin
    int s, lr, cc, t;
    vec_t v;
    tbl[0] = '{16'h0100, 16'd4, 16'h0200, 3, 0,  1'b1, 1'b0, 1'b0, 16'h0119, 16'h011C, 29, 28, 1};
    tbl[1] = '{16'h0100, 16'd4, 16'h0200, 0, 10, 1'b1, 1'b0, 1'b0, 16'h0119, 16'h011C, 29, 38, 1};
    tbl[2] = '{16'hFFF0, 16'd2, 16'h0010, 1, 0,  1'b1, 1'b0, 1'b0, 16'h0009, 16'h000A, 27, 28, 1};
    tbl[3] = '{16'h0010, 16'd0, 16'h0020, 1, 0,  1'b1, 1'b0, 1'b0, 16'h0029, 16'h0029, 26, 28, 1};
    tbl[4] = '{16'h0300, 16'd3, 16'h0400, 2, 0,  1'b0, 1'b0, 1'b1, 16'h0319, 16'h031B, 28, 28, 16};
    tbl[5] = '{16'h0500, 16'd2, 16'h0600, 0, 0,  1'b0, 1'b1, 1'b0, 16'h0519, 16'h051A, 27, 28, 2};
    repeat (2) step();
    chk("reset_outputs", 32'(any_out()), 0);
    rst_n = 1;
    step();
    for (int n = 0; n < 6; n++) begin
      run_layer(tbl[n], s, lr, cc);
      check_layer(tbl[n], s, tbl[n].err);
      chk("n_rd", rd_adr.size(), tbl[n].n_rd);
      if (rd_adr.size() == tbl[n].n_rd) begin
        chk("px_first_addr", 32'(rd_adr[WT]), 32'(tbl[n].a_px));
        chk("last_addr", 32'(rd_adr[tbl[n].n_rd - 1]), 32'(tbl[n].a_last));
        chk("px_ofs", rd_cyc[WT] - s, tbl[n].px_ofs);
        if (done_cyc.size() > 0)
          chk("done_ofs", done_cyc[0] - (tbl[n].cd ? cc : tbl[n].ecd ? rd_cyc[tbl[n].n_rd - 1] : lr),
              tbl[n].done_ofs);
      end
    end
    acc_rvalid = 1; acc_rdata = 32'h1234_5678;
    #1;
    chk("idle_wr_en", 32'(mem_wr_en), 0);
    chk("idle_bus_free", 32'(bus_free), 0);
    step();
    acc_rvalid = 0;
    run_layer(tbl[0], s, lr, cc);
    check_layer(tbl[0], s, 1'b1);
    run_layer(tbl[0], s, lr, cc);
    check_layer(tbl[0], s, 1'b0);
    clear();
    src_base = 16'h0700; px_words = 16'd8; dst_base = 16'h0800; start = 1;
    step();
    start = 0;
    t = 0;
    while (rd_adr.size() <= WT + 1 && t < 200) begin step(); t++; end
    chk("pixel_reached", 32'(t < 200), 1);
    rst_n = 0; acc_rvalid = 1; acc_rdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_outputs_zero", 32'(any_out()), 0);
    repeat (3) step();
    chk("rst_no_done", done_cyc.size(), 0);
    chk("rst_no_write", wr_adr.size(), 0);
    rst_n = 1; acc_rvalid = 0;
    step();
    run_layer(tbl[0], s, lr, cc);
    check_layer(tbl[0], s, 1'b0);
    for (int n = 0; n < 6; n++) begin
      v = tbl[0];
      v.src = 16'($urandom); v.px = 16'($urandom_range(0, 9)); v.dst = 16'($urandom);
      v.nres = $urandom_range(0, 4); v.hold = $urandom_range(0, 5);
      run_layer(v, s, lr, cc);
      check_layer(v, s, 1'b0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
